// File: rtl/pc_stack_counter.sv
// Program counter with bundle/slot address fields and a hardware call/return stack.
// One command acts per cycle: ret > call > jump > branch > update_msbs > update_lsbs.
module pc_stack_counter #(
  parameter int ADDR_W      = 8,
  parameter int LSB_W       = 2,
  parameter int STACK_DEPTH = 4,
  parameter int LSB_CARRY   = 0,
  localparam int MSB_W      = ADDR_W - LSB_W,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_lsbs,
  input  logic              update_msbs,
  input  logic              jump,
  input  logic [MSB_W-1:0]  jump_destination,
  input  logic              branch,
  input  logic [MSB_W-1:0]  branch_offset,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LVL_W-1:0]  stack_level,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [MSB_W-1:0]  msbs;
  logic [LSB_W-1:0]  lsbs;
  logic [MSB_W-1:0]  next_bundle;
  logic [ADDR_W-1:0] pc_inc;
  logic [LVL_W-1:0]  level_dec;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] top_entry;
  logic              do_push;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign mem_addr    = {msbs, lsbs};
  assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
  assign stack_empty = (stack_level == '0);

  assign next_bundle = msbs + 1'b1;
  assign pc_inc      = mem_addr + 1'b1;
  assign level_dec   = stack_level - 1'b1;
  assign push_idx    = stack_level[PTR_W-1:0];
  assign pop_idx     = level_dec[PTR_W-1:0];
  assign top_entry   = stack_mem[pop_idx];

  // A push only happens when call is the winning command and there is room.
  assign do_push = call & ~ret & ~rst & ~stack_full;

  // Stack storage carries no reset; stack_level alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[push_idx] <= {next_bundle, {LSB_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msbs        <= '0;
      lsbs        <= '0;
      stack_level <= '0;
      stack_err   <= 1'b0;
    end else if (ret) begin
      if (stack_empty) begin
        stack_err <= 1'b1;
      end else begin
        {msbs, lsbs} <= top_entry;
        stack_level  <= level_dec;
      end
    end else if (call) begin
      if (stack_full) begin
        stack_err <= 1'b1;
      end else begin
        msbs        <= jump_destination;
        lsbs        <= '0;
        stack_level <= stack_level + 1'b1;
      end
    end else if (jump) begin
      msbs <= jump_destination;
      lsbs <= '0;
    end else if (branch) begin
      // Modular addition of equal-width operands is the signed add we want.
      msbs <= msbs + branch_offset;
      lsbs <= '0;
    end else if (update_msbs) begin
      msbs <= next_bundle;
    end else if (update_lsbs) begin
      if (LSB_CARRY != 0) begin
        {msbs, lsbs} <= pc_inc;
      end else begin
        lsbs <= lsbs + 1'b1;
      end
    end
  end

endmodule
